// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, machine interrupts and mret, then sequences csrfile handoff and redirect.
// Optional build macro TRAP_CTRL_VECTORED_EN adds vectored interrupt targets (mtvec mode 01).
module trap_ctrl #(
    parameter int XLEN           = 32,
    parameter int HANDLE_TIMEOUT = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 exc_valid,
    output logic                 exc_ready,
    input  logic [3:0]           exc_cause,
    input  logic [XLEN-1:0]      exc_value,
    input  logic [XLEN-1:0]      exc_pc,
    input  logic                 irq_ext,
    input  logic                 irq_sw,
    input  logic                 irq_timer,
    input  logic                 mie_global,
    input  logic [2:0]           mie_mask,
    input  logic [XLEN-1:0]      irq_pc,
    input  logic                 mret_valid,
    input  logic [XLEN-1:0]      mepc_in,
    output logic                 trap,
    output logic [3:0]           trap_cause,
    output logic                 trap_is_irq,
    output logic [XLEN-1:0]      trap_value,
    output logic [XLEN-1:0]      trap_pc,
    input  logic                 trap_handled,
    input  logic [XLEN-1:0]      trap_target_pc,
    output logic                 stall,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] trap_count
);

    // state | meaning
    // IDLE  | arbitrating; only state that accepts requests
    // ISSUE | one-cycle trap pulse to csrfile
    // WAIT  | waiting for trap_handled, timeout counter running
    // REDIR | one-cycle flush + redirect to handler
    // RET   | one-cycle flush + redirect to captured mepc
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, REDIR, RET} state_t;

    localparam int TW = (HANDLE_TIMEOUT < 2) ? 1 : $clog2(HANDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(HANDLE_TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [TW-1:0]   wait_cnt;
    logic [3:0]      cause_q;
    logic            is_irq_q;
    logic [XLEN-1:0] value_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ret_pc_q;

    logic [2:0]      irq_pend;
    logic            accept_trap;
    logic            accept_mret;
    logic [3:0]      sel_cause;
    logic            sel_irq;
    logic [XLEN-1:0] sel_value;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] handler_pc;
    logic            unused_bits;

    // irq_pend bit order follows mie_mask: {ext, timer, sw}
    assign irq_pend    = {irq_ext, irq_timer, irq_sw} & mie_mask & {3{mie_global}};
    assign accept_trap = (state == IDLE) && (exc_valid || (irq_pend != 3'b000));
    assign accept_mret = (state == IDLE) && mret_valid && !accept_trap;
    assign unused_bits = ^{mepc_in[1:0], trap_target_pc[1:0]};

    always_comb begin
        sel_cause = exc_cause;
        sel_irq   = 1'b0;
        sel_value = exc_value;
        sel_pc    = exc_pc;
        if (!exc_valid) begin
            sel_irq   = 1'b1;
            sel_value = '0;
            sel_pc    = irq_pc;
            if (irq_pend[2])      sel_cause = 4'd11;
            else if (irq_pend[0]) sel_cause = 4'd3;
            else                  sel_cause = 4'd7;
        end
    end

    always_comb begin
        handler_pc = {trap_target_pc[XLEN-1:2], 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
        if (is_irq_q && (trap_target_pc[1:0] == 2'b01))
            handler_pc = {trap_target_pc[XLEN-1:2], 2'b00} + {{(XLEN-6){1'b0}}, cause_q, 2'b00};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        exc_ready      = 1'b0;
        stall          = 1'b0;
        trap           = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        timeout_err    = 1'b0;
        case (state)
            IDLE: begin
                exc_ready = 1'b1;
                if (accept_trap)      state_nxt = ISSUE;
                else if (accept_mret) state_nxt = RET;
            end
            ISSUE: begin
                stall     = 1'b1;
                trap      = 1'b1;
                state_nxt = trap_handled ? REDIR : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (trap_handled) begin
                    state_nxt = REDIR;
                end else if (wait_cnt == TO_LAST) begin
                    timeout_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            REDIR: begin
                stall          = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = handler_pc;
                state_nxt      = IDLE;
            end
            RET: begin
                stall          = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = ret_pc_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            cause_q    <= '0;
            is_irq_q   <= 1'b0;
            value_q    <= '0;
            pc_q       <= '0;
            ret_pc_q   <= '0;
            trap_count <= '0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (accept_trap) begin
                cause_q  <= sel_cause;
                is_irq_q <= sel_irq;
                value_q  <= sel_value;
                pc_q     <= sel_pc;
            end
            if (accept_mret)
                ret_pc_q <= {mepc_in[XLEN-1:2], 2'b00};
            if ((state == REDIR) && (trap_count != '1))
                trap_count <= trap_count + 1'b1;
        end
    end

    assign trap_cause  = cause_q;
    assign trap_is_irq = is_irq_q;
    assign trap_value  = value_q;
    assign trap_pc     = pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl; inputs driven and outputs sampled on the falling edge.
// Build with TRAP_CTRL_VECTORED_EN defined to check vectored interrupt targets.
module tb_trap_ctrl;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            exc_valid, exc_ready;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_value, exc_pc;
    logic            irq_ext, irq_sw, irq_timer, mie_global;
    logic [2:0]      mie_mask;
    logic [XLEN-1:0] irq_pc;
    logic            mret_valid;
    logic [XLEN-1:0] mepc_in;
    logic            trap;
    logic [3:0]      trap_cause;
    logic            trap_is_irq;
    logic [XLEN-1:0] trap_value, trap_pc;
    logic            trap_handled;
    logic [XLEN-1:0] trap_target_pc;
    logic            stall, flush, redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            timeout_err;
    logic [15:0]     trap_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .HANDLE_TIMEOUT(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_cause(exc_cause),
        .exc_value(exc_value), .exc_pc(exc_pc),
        .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
        .mie_global(mie_global), .mie_mask(mie_mask), .irq_pc(irq_pc),
        .mret_valid(mret_valid), .mepc_in(mepc_in),
        .trap(trap), .trap_cause(trap_cause), .trap_is_irq(trap_is_irq),
        .trap_value(trap_value), .trap_pc(trap_pc),
        .trap_handled(trap_handled), .trap_target_pc(trap_target_pc),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .timeout_err(timeout_err), .trap_count(trap_count)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; exc_valid = 0; exc_cause = 0; exc_value = 0; exc_pc = 0;
        irq_ext = 0; irq_sw = 0; irq_timer = 0; mie_global = 0; mie_mask = 0;
        irq_pc = 0; mret_valid = 0; mepc_in = 0; trap_handled = 0; trap_target_pc = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({exc_ready, trap, flush, redirect_valid, stall, timeout_err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready/trap/flush/redir/stall/to=%b want 100000",
                     {exc_ready, trap, flush, redirect_valid, stall, timeout_err});
        end
        n_checks++;
        if (trap_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", trap_count);
        end
        n_checks++;
        if ({trap_cause, trap_value, trap_pc, trap_is_irq, redirect_pc} !== '0) begin
            n_fail++; $display("FAIL reset_fields: got nonzero latched/redirect fields, want 0");
        end
    endtask

    task automatic test_exception();
        exc_valid = 1; exc_cause = 4'd11; exc_value = 32'hDEADBEEF; exc_pc = 32'h20;
        trap_target_pc = 32'h10;
        step();
        exc_valid = 0; exc_cause = 0; exc_value = 0; exc_pc = 0;
        n_checks++;
        if ({trap, stall, exc_ready} !== 3'b110) begin
            n_fail++; $display("FAIL exc_issue: got trap/stall/ready=%b want 110", {trap, stall, exc_ready});
        end
        n_checks++;
        if (trap_cause !== 4'd11 || trap_value !== 32'hDEADBEEF || trap_pc !== 32'h20 || trap_is_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_fields: got cause=%0d value=%h pc=%h irq=%b want 11 deadbeef 20 0",
                     trap_cause, trap_value, trap_pc, trap_is_irq);
        end
        trap_handled = 1;
        step();
        trap_handled = 0;
        n_checks++;
        if ({trap, flush, redirect_valid} !== 3'b011 || redirect_pc !== 32'h10) begin
            n_fail++;
            $display("FAIL exc_redir: got trap/flush/rv=%b pc=%h want 011 10", {trap, flush, redirect_valid}, redirect_pc);
        end
        step();
        n_checks++;
        if (trap_count !== 16'd1 || exc_ready !== 1'b1 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_done: got count=%0d ready=%b flush=%b want 1 1 0", trap_count, exc_ready, flush);
        end
    endtask

    task automatic test_irq_priority();
        irq_ext = 1; irq_timer = 1; mie_global = 1; mie_mask = 3'b111; irq_pc = 32'h40;
        trap_target_pc = 32'h201;
        step();
        n_checks++;
        if (trap !== 1'b1 || trap_cause !== 4'd11 || trap_is_irq !== 1'b1 || trap_pc !== 32'h40 || trap_value !== 0) begin
            n_fail++;
            $display("FAIL irq_ext: got trap=%b cause=%0d irq=%b pc=%h value=%h want 1 11 1 40 0",
                     trap, trap_cause, trap_is_irq, trap_pc, trap_value);
        end
        trap_handled = 1;
        step();
        trap_handled = 0;
        irq_ext = 0;
        n_checks++;
`ifdef TRAP_CTRL_VECTORED_EN
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h22C) begin
            n_fail++; $display("FAIL irq_ext_redir: got rv=%b pc=%h want 1 22c", redirect_valid, redirect_pc);
        end
`else
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
            n_fail++; $display("FAIL irq_ext_redir: got rv=%b pc=%h want 1 200", redirect_valid, redirect_pc);
        end
`endif
        step();
        step();
        n_checks++;
        if (trap !== 1'b1 || trap_cause !== 4'd7 || trap_is_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_timer: got trap=%b cause=%0d irq=%b want 1 7 1", trap, trap_cause, trap_is_irq);
        end
        trap_handled = 1;
        step();
        trap_handled = 0;
        irq_timer = 0;
        n_checks++;
`ifdef TRAP_CTRL_VECTORED_EN
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h21C) begin
            n_fail++; $display("FAIL irq_timer_redir: got rv=%b pc=%h want 1 21c", redirect_valid, redirect_pc);
        end
`else
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
            n_fail++; $display("FAIL irq_timer_redir: got rv=%b pc=%h want 1 200", redirect_valid, redirect_pc);
        end
`endif
        step();
        n_checks++;
        if (trap_count !== 16'd3 || exc_ready !== 1'b1) begin
            n_fail++; $display("FAIL irq_done: got count=%0d ready=%b want 3 1", trap_count, exc_ready);
        end
    endtask

    task automatic test_irq_masked();
        irq_ext = 1; irq_timer = 1; mie_global = 0; mie_mask = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({trap, stall, exc_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL irq_masked: cycle %0d got trap/stall/ready=%b want 001", i, {trap, stall, exc_ready});
            end
        end
        irq_ext = 0; irq_timer = 0; mie_mask = 0;
    endtask

    task automatic test_exc_vs_mret();
        exc_valid = 1; exc_cause = 4'd3; exc_value = 32'h5; exc_pc = 32'h80;
        mret_valid = 1; mepc_in = 32'h100; trap_target_pc = 32'h10;
        step();
        exc_valid = 0; mret_valid = 0;
        n_checks++;
        if (trap !== 1'b1 || trap_cause !== 4'd3 || trap_pc !== 32'h80 || redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_mret_issue: got trap=%b cause=%0d pc=%h rv=%b want 1 3 80 0",
                     trap, trap_cause, trap_pc, redirect_valid);
        end
        trap_handled = 1;
        step();
        trap_handled = 0;
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h10) begin
            n_fail++; $display("FAIL exc_mret_redir: got rv=%b pc=%h want 1 10", redirect_valid, redirect_pc);
        end
        step();
        n_checks++;
        if (redirect_valid !== 1'b0 || exc_ready !== 1'b1 || trap_count !== 16'd4) begin
            n_fail++;
            $display("FAIL exc_mret_drop: got rv=%b ready=%b count=%0d want 0 1 4", redirect_valid, exc_ready, trap_count);
        end
        mret_valid = 1; mepc_in = 32'h100;
        step();
        mret_valid = 0; mepc_in = 32'h204;
        n_checks++;
        if ({flush, redirect_valid, trap, stall} !== 4'b1101 || redirect_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL mret_redir: got flush/rv/trap/stall=%b pc=%h want 1101 100",
                     {flush, redirect_valid, trap, stall}, redirect_pc);
        end
        step();
        n_checks++;
        if (exc_ready !== 1'b1 || flush !== 1'b0 || trap_count !== 16'd4) begin
            n_fail++;
            $display("FAIL mret_done: got ready=%b flush=%b count=%0d want 1 0 4", exc_ready, flush, trap_count);
        end
    endtask

    task automatic test_timeout();
        int stall_cycles = 0;
        int to_pulses = 0;
        int to_at = -1;
        int flushes = 0;
        exc_valid = 1; exc_cause = 4'd2; exc_value = 32'h1; exc_pc = 32'h90;
        step();
        exc_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (stall !== 1'b1) break;
            stall_cycles++;
            if (timeout_err === 1'b1) begin to_pulses++; to_at = stall_cycles; end
            if (flush === 1'b1 || redirect_valid === 1'b1) flushes++;
            step();
        end
        n_checks++;
        if (stall_cycles !== 9) begin
            n_fail++; $display("FAIL timeout_len: got %0d busy cycles want 9", stall_cycles);
        end
        n_checks++;
        if (to_pulses !== 1 || to_at !== 9) begin
            n_fail++; $display("FAIL timeout_pulse: got %0d pulses at cycle %0d want 1 at 9", to_pulses, to_at);
        end
        n_checks++;
        if (flushes !== 0 || trap_count !== 16'd4 || exc_ready !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_after: got flushes=%0d count=%0d ready=%b to=%b want 0 4 1 0",
                     flushes, trap_count, exc_ready, timeout_err);
        end
    endtask

    task automatic test_back_to_back();
        exc_valid = 1; exc_cause = 4'd4; exc_value = 0; exc_pc = 32'hA0; trap_target_pc = 32'h30;
        step();
        exc_cause = 4'd5; exc_pc = 32'hB0;
        n_checks++;
        if (trap !== 1'b1 || trap_cause !== 4'd4) begin
            n_fail++; $display("FAIL b2b_first: got trap=%b cause=%0d want 1 4", trap, trap_cause);
        end
        trap_handled = 1;
        step();
        trap_handled = 0;
        step();
        n_checks++;
        if (exc_ready !== 1'b1 || trap_cause !== 4'd4) begin
            n_fail++; $display("FAIL b2b_idle: got ready=%b cause=%0d want 1 4", exc_ready, trap_cause);
        end
        step();
        exc_valid = 0;
        n_checks++;
        if (trap !== 1'b1 || trap_cause !== 4'd5 || trap_pc !== 32'hB0 || trap_count !== 16'd5) begin
            n_fail++;
            $display("FAIL b2b_second: got trap=%b cause=%0d pc=%h count=%0d want 1 5 b0 5",
                     trap, trap_cause, trap_pc, trap_count);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++;
        if ({exc_ready, trap, flush, redirect_valid, stall} !== 5'b10000 || trap_count !== 16'd0 || trap_cause !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got ready/trap/flush/rv/stall=%b count=%0d cause=%0d want 10000 0 0",
                     {exc_ready, trap, flush, redirect_valid, stall}, trap_count, trap_cause);
        end
        step();
        n_checks++;
        if (flush !== 1'b0 || redirect_valid !== 1'b0 || exc_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_after: got flush=%b rv=%b ready=%b want 0 0 1", flush, redirect_valid, exc_ready);
        end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_irq_priority();
        test_irq_masked();
        test_exc_vs_mret();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer in front of csrfile. Arbitrates synchronous exceptions from the pipeline and level-sensitive machine interrupts (external, software, timer).
- Sequences one trap at a time into csrfile's trap/trap_cause/trap_value/trap_pc interface and waits for trap_handled.
- Then issues a one-cycle pipeline flush and redirect to the handler.
- Also sequences mret returns to mepc.

Parameters:
- XLEN, 32, data/address width.
- HANDLE_TIMEOUT, 8, cycles to wait for trap_handled before abort; minimum 1.
- CNT_WIDTH, 16, width of the trap_count statistic.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- exc_valid  in  1  pipeline exception request.
- exc_ready  out  1  exception accepted this cycle.
- exc_cause  in  4  exception code (e.g. 3 = breakpoint, 11 = ECALL_M).
- exc_value  in  XLEN  mtval value for the exception.
- exc_pc  in  XLEN  pc of the faulting instruction.
- irq_ext, irq_sw, irq_timer  in  1 each  level interrupt lines.
- mie_global  in  1  mstatus.MIE.
- mie_mask  in  3  per-source enables {ext, timer, sw}.
- irq_pc  in  XLEN  pc of the next unretired instruction (mepc for interrupts).
- mret_valid  in  1  mret retiring.
- mepc_in  in  XLEN  current mepc from csrfile.
- trap  out  1  to csrfile, one-cycle pulse.
- trap_cause  out  4  to csrfile.
- trap_is_irq  out  1  interrupt flag for mcause bit 31.
- trap_value  out  XLEN  to csrfile.
- trap_pc  out  XLEN  to csrfile.
- trap_handled  in  1  from csrfile.
- trap_target_pc  in  XLEN  mtvec-derived target from csrfile.
- stall  out  1  pipeline hold while busy.
- flush  out  1  one-cycle flush pulse.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  XLEN  redirect address.
- timeout_err  out  1  one-cycle pulse on handler timeout.
- trap_count  out  CNT_WIDTH  traps completed; saturates at all-ones.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State = IDLE.
  - All outputs 0, including trap_count, except exc_ready = 1.
  - Latched trap fields cleared; timeout counter cleared.
  - Reset asserted mid-sequence aborts the sequence with no flush/redirect pulse.
- States:
  - IDLE -> ISSUE on an accepted trap.
  - IDLE -> RET on an accepted mret.
  - ISSUE -> WAIT.
  - WAIT -> REDIR on trap_handled.
  - WAIT -> IDLE on timeout.
  - REDIR -> IDLE.
  - RET -> IDLE.
- exc_ready = 1 only in IDLE.
- stall = 1 in ISSUE, WAIT, REDIR and RET.
- Arbitration in IDLE, priority highest first:
  1. exc_valid.
  2. Pending interrupt, where pending = mie_global & line & mask bit. Order among interrupts: ext (cause 11) > sw (cause 3) > timer (cause 7).
  3. mret_valid.
- Simultaneous mret and trap: the trap wins and the mret is dropped; the pipeline must not retire it.
- Acceptance edge latches cause, value, pc and is_irq:
  - Exception: exc_value, exc_pc, is_irq = 0.
  - Interrupt: value = 0, pc = irq_pc, is_irq = 1.
- ISSUE: trap = 1 for exactly one cycle, driving the latched fields. Fields hold stable until the state returns to IDLE.
- WAIT:
  - Counter increments each cycle.
  - trap_handled seen in ISSUE or WAIT -> REDIR next edge; trap_handled also sampled during the ISSUE cycle.
  - Counter reaching HANDLE_TIMEOUT with no trap_handled -> timeout_err pulse, return to IDLE, no redirect.
- REDIR:
  - flush = redirect_valid = 1 for one cycle.
  - redirect_pc = {trap_target_pc[XLEN-1:2], 2'b00} (sampled in REDIR).
  - trap_count += 1, saturating.
- RET: flush = redirect_valid = 1 for one cycle; redirect_pc = {mepc_in[XLEN-1:2], 2'b00} as captured on acceptance.
- Latency:
  - Request accepted at edge N -> trap high in cycle N+1.
  - trap_handled in cycle N+1 -> redirect pulse in cycle N+2.
  - mret accepted at edge N -> redirect in cycle N+1.
- Inputs arriving while not in IDLE are ignored. Interrupt lines are levels and are re-evaluated on return to IDLE.
- Back-to-back traps are allowed; there are no dead cycles beyond the IDLE arbitration cycle.

Optional Feature:
- Macro: TRAP_CTRL_VECTORED_EN.
- Defined: for interrupts with trap_target_pc[1:0] == 2'b01, redirect_pc = {trap_target_pc[XLEN-1:2], 2'b00} + 4*cause. Exceptions and mode 00 are unchanged.
- Undefined: redirect_pc = {trap_target_pc[XLEN-1:2], 2'b00} for all traps (direct mode only).

Test Plan:
- Reset, no requests -> exc_ready = 1; trap, flush, redirect_valid, stall = 0; trap_count = 0.
- exc_valid with cause = 11, value = 0xDEADBEEF, pc = 0x20; csrfile returns handled in the ISSUE cycle with target 0x10 -> trap pulse one cycle after acceptance carrying 11/0xDEADBEEF/0x20/irq = 0; redirect_pc = 0x10 the next cycle; trap_count = 1.
- irq_timer and irq_ext both high, mie_global = 1, mask = 3'b111, irq_pc = 0x40 -> cause 11 is issued with is_irq = 1 and pc = 0x40; after return, the timer (cause 7) is issued next.
- Same stimulus with mie_global = 0 -> no trap, exc_ready remains 1.
- exc_valid and mret_valid in the same cycle with mepc_in = 0x100 -> the exception is sequenced and no redirect to 0x100 occurs. Later, a lone mret -> redirect_pc = 0x100 one cycle after acceptance.
- trap_handled never asserted -> timeout_err pulse after 8 WAIT cycles, no flush, return to IDLE, trap_count unchanged.
- With TRAP_CTRL_VECTORED_EN, timer interrupt with target 0x201 -> redirect_pc = 0x21C.
